// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
//
// Divides a 2*WIDTH-bit unsigned dividend by a WIDTH-bit unsigned divisor and
// produces a WIDTH-bit quotient and remainder. It is the inverse of the 32x32
// multiplier, so products can be checked by round-trip.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        request; sampled only while idle
//   dividend     2*WIDTH-bit numerator, captured on an accepted start
//   divisor      WIDTH-bit denominator, captured on an accepted start
//   busy         high while a division is in progress
//   done         one-cycle pulse, results valid
//   quotient     WIDTH-bit quotient (all ones on an error)
//   remainder    WIDTH-bit remainder (zero on an error)
//   div_by_zero  divisor was zero for the last operation
//   overflow     quotient did not fit in WIDTH bits for the last operation
//   dbg_state    current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: start is a request, honoured only in IDLE. A start while busy is
// dropped, not queued. done pulses for one cycle on the edge that writes the
// results; start may be high in that same cycle and is accepted. Results and
// flags hold until the next accepted start produces new ones.

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow,
  output logic                 dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  // Working registers, kept apart from the output registers so the outputs
  // stay stable for the whole RUN phase.
  logic [WIDTH-1:0] prem;     // partial remainder; always < divisor
  logic [WIDTH-1:0] dvd_lo;   // remaining low dividend bits, MSB next
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] qwork;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] hi;
  logic             div_zero;
  logic             ovf_req;
  logic             accept;
  logic             last;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_diff_bit;

  assign hi       = dividend[2*WIDTH-1:WIDTH];
  assign div_zero = (divisor == '0);
  // The quotient fits in WIDTH bits exactly when the upper dividend half is
  // below the divisor.
  assign ovf_req  = !div_zero && (hi >= divisor);
  assign accept   = start && !div_zero && !ovf_req;
  assign last     = (cnt == CW'(WIDTH - 1));

  // One restoring step. The shifted value needs WIDTH+1 bits; subtracting in
  // WIDTH+2 bits lets the top bit act as the borrow (i.e. shifted < divisor).
  assign shifted  = {prem, dvd_lo[WIDTH-1]};
  assign diff     = {1'b0, shifted} - {2'b00, dvsr};
  assign ge       = !diff[WIDTH+1];
  assign rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_next   = {qwork[WIDTH-2:0], ge};
  // After a successful subtract the result is below the divisor, so bit WIDTH
  // of the difference is always zero when it is selected.
  assign unused_diff_bit = diff[WIDTH];

  assign dbg_state = (state == RUN);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prem        <= '0;
      dvd_lo      <= '0;
      dvsr        <= '0;
      qwork       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              done        <= 1'b1;
            end else if (ovf_req) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              done        <= 1'b1;
            end else begin
              dvsr        <= divisor;
              dvd_lo      <= dividend[WIDTH-1:0];
              prem        <= hi;
              qwork       <= '0;
              cnt         <= '0;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end
        end
        RUN: begin
          prem   <= rem_next;
          qwork  <= q_next;
          dvd_lo <= {dvd_lo[WIDTH-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
          if (last) begin
            quotient  <= q_next;
            remainder <= rem_next;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
